// File: rtl/hazard_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_pkg
// Shared constants and helpers for the pipeline hazard control unit.
//   HCU_RUN / HCU_MD_BUSY   : sequencing state encoding
//   HCU_X0                  : architectural zero register index
//   HCU_MD_TIMEOUT_DEFAULT  : default MUL/DIV watchdog limit
//   hcu_ctrl_t              : bundle of all pipeline control outputs
// -----------------------------------------------------------------------------
package hazard_control_unit_pkg;

  localparam logic [0:0] HCU_RUN     = 1'b0;
  localparam logic [0:0] HCU_MD_BUSY = 1'b1;

  localparam logic [4:0] HCU_X0 = 5'd0;

  localparam int HCU_MD_TIMEOUT_DEFAULT = 64;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic md_start;
    logic md_abort;
  } hcu_ctrl_t;

  // Free-running pipeline: everything advances, nothing squashed.
  function automatic hcu_ctrl_t hcu_run_ctrl();
    hcu_ctrl_t c;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.if_id_flush  = 1'b0;
    c.id_ex_write  = 1'b1;
    c.id_ex_flush  = 1'b0;
    c.ex_mem_flush = 1'b0;
    c.md_start     = 1'b0;
    c.md_abort     = 1'b0;
    return c;
  endfunction

  // Front end frozen while EX holds a MUL/DIV; EX/MEM receives bubbles.
  function automatic hcu_ctrl_t hcu_freeze_ctrl();
    hcu_ctrl_t c;
    c.pc_write     = 1'b0;
    c.if_id_write  = 1'b0;
    c.if_id_flush  = 1'b0;
    c.id_ex_write  = 1'b0;
    c.id_ex_flush  = 1'b0;
    c.ex_mem_flush = 1'b1;
    c.md_start     = 1'b0;
    c.md_abort     = 1'b0;
    return c;
  endfunction

  // Reset: hold every stage and flush the pipeline registers.
  function automatic hcu_ctrl_t hcu_reset_ctrl();
    hcu_ctrl_t c;
    c.pc_write     = 1'b0;
    c.if_id_write  = 1'b0;
    c.if_id_flush  = 1'b1;
    c.id_ex_write  = 1'b0;
    c.id_ex_flush  = 1'b1;
    c.ex_mem_flush = 1'b1;
    c.md_start     = 1'b0;
    c.md_abort     = 1'b0;
    return c;
  endfunction

  // A source operand depends on rd only if it is actually read.
  function automatic logic hcu_src_match(input logic [4:0] rd,
                                         input logic [4:0] rs,
                                         input logic       use_rs);
    return use_rs && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_md_watchdog.sv
// -----------------------------------------------------------------------------
// hcu_md_watchdog
// Counts cycles spent in MD_BUSY and flags the last permitted cycle.
//   clk, rst  : core clock, synchronous active-high reset
//   clear     : restart the count (asserted with the MUL/DIV start pulse)
//   busy      : the controller is in MD_BUSY this cycle
//   timeout   : busy and this is busy cycle number MD_TIMEOUT
// -----------------------------------------------------------------------------
module hcu_md_watchdog
  import hazard_control_unit_pkg::*;
#(
  parameter int MD_TIMEOUT = HCU_MD_TIMEOUT_DEFAULT,
  parameter int CNT_W      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: cleared on start, advanced once per busy cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (busy) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count starts at zero on the first busy cycle.
  assign timeout = busy && (cnt_q == CNT_LAST);

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline sequencing controller for the 5-stage RV32 core. Resolves load-use
// (one bubble), taken branch/jump (flush IF/ID and ID/EX) and multi-cycle
// MUL/DIV (freeze front end until md_done, with a watchdog abort).
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   IF_ID_rs1/rs2, use_rs1/rs2    source registers of the ID instruction
//   ID_EX_rd, ID_EX_MemRead       destination / load flag of the EX instruction
//   ID_EX_MulDiv                  EX instruction is a multi-cycle MUL/DIV
//   branch_taken                  EX resolved a taken branch/jump
//   md_done                       MUL/DIV result valid pulse
//   PC_Write, IF_ID_Write/Flush,  stage enables and flushes
//   ID_EX_Write/Flush, EX_MEM_Flush
//   md_start, md_abort            MUL/DIV start and watchdog abort pulses
// Optional (macro HAZARD_PERF_CNT_EN): stall_cycles, flush_events counters.
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MD_TIMEOUT = HCU_MD_TIMEOUT_DEFAULT,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_rs1,
  input  logic [4:0] IF_ID_rs2,
  input  logic       IF_ID_use_rs1,
  input  logic       IF_ID_use_rs2,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_MulDiv,
  input  logic       branch_taken,
  input  logic       md_done,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Write,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Flush,
  output logic       md_start,
  output logic       md_abort
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  hcu_ctrl_t  ctrl_s;
  logic       load_use_s;
  logic       wd_clear_s;
  logic       wd_busy_s;
  logic       wd_timeout_s;
  logic       branch_flush_s;

  assign load_use_s = ID_EX_MemRead && (ID_EX_rd != HCU_X0) &&
                      (hcu_src_match(ID_EX_rd, IF_ID_rs1, IF_ID_use_rs1) ||
                       hcu_src_match(ID_EX_rd, IF_ID_rs2, IF_ID_use_rs2));

  assign wd_busy_s = (state_q == HCU_MD_BUSY);

  hcu_md_watchdog #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_md_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear_s),
    .busy    (wd_busy_s),
    .timeout (wd_timeout_s)
  );

  // Control decode and next state; priority in RUN is branch > MUL/DIV > load-use.
  always_comb begin
    ctrl_s         = hcu_run_ctrl();
    state_d        = state_q;
    wd_clear_s     = 1'b0;
    branch_flush_s = 1'b0;
    if (rst) begin
      ctrl_s  = hcu_reset_ctrl();
      state_d = HCU_RUN;
    end else begin
      case (state_q)
        HCU_RUN: begin
          if (branch_taken) begin
            // The ID instruction is squashed, so any load-use stall is moot.
            ctrl_s.if_id_flush = 1'b1;
            ctrl_s.id_ex_flush = 1'b1;
            ctrl_s.pc_write    = 1'b1;
            branch_flush_s     = 1'b1;
          end else if (ID_EX_MulDiv) begin
            ctrl_s          = hcu_freeze_ctrl();
            ctrl_s.md_start = 1'b1;
            wd_clear_s      = 1'b1;
            state_d         = HCU_MD_BUSY;
          end else if (load_use_s) begin
            ctrl_s.pc_write    = 1'b0;
            ctrl_s.if_id_write = 1'b0;
            ctrl_s.id_ex_flush = 1'b1;
          end else begin
            ctrl_s = hcu_run_ctrl();
          end
        end
        HCU_MD_BUSY: begin
          if (md_done) begin
            // Release in the done cycle so the result enters EX/MEM.
            ctrl_s  = hcu_run_ctrl();
            state_d = HCU_RUN;
          end else if (wd_timeout_s) begin
            ctrl_s          = hcu_freeze_ctrl();
            ctrl_s.md_abort = 1'b1;
            state_d         = HCU_RUN;
          end else begin
            ctrl_s = hcu_freeze_ctrl();
          end
        end
        default: begin
          ctrl_s  = hcu_reset_ctrl();
          state_d = HCU_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HCU_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign PC_Write     = ctrl_s.pc_write;
  assign IF_ID_Write  = ctrl_s.if_id_write;
  assign IF_ID_Flush  = ctrl_s.if_id_flush;
  assign ID_EX_Write  = ctrl_s.id_ex_write;
  assign ID_EX_Flush  = ctrl_s.id_ex_flush;
  assign EX_MEM_Flush = ctrl_s.ex_mem_flush;
  assign md_start     = ctrl_s.md_start;
  assign md_abort     = ctrl_s.md_abort;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;
  logic [31:0] flush_events_q;
  logic [31:0] flush_events_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!rst && !ctrl_s.pc_write) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (branch_flush_s) begin
      flush_events_d = flush_events_q + 32'd1;
    end else begin
      flush_events_d = flush_events_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed and randomized bench for hazard_control_unit with a behavioural
// reference model. Built with MD_TIMEOUT=8 so the watchdog is reachable.
// Output vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
//                       ID_EX_Flush, EX_MEM_Flush, md_start, md_abort}
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic       IF_ID_use_rs1, IF_ID_use_rs2;
  logic       ID_EX_MemRead, ID_EX_MulDiv, branch_taken, md_done;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
  logic       ID_EX_Flush, EX_MEM_Flush, md_start, md_abort;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: in a MUL/DIV, and which busy cycle (1-based) this is.
  bit          m_busy   = 1'b0;
  int          m_busy_n = 0;
  logic [31:0] m_stall  = 32'd0;
  logic [31:0] m_flush  = 32'd0;

  hazard_control_unit #(.MD_TIMEOUT(TO), .CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .IF_ID_rs1     (IF_ID_rs1),
    .IF_ID_rs2     (IF_ID_rs2),
    .IF_ID_use_rs1 (IF_ID_use_rs1),
    .IF_ID_use_rs2 (IF_ID_use_rs2),
    .ID_EX_rd      (ID_EX_rd),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_MulDiv  (ID_EX_MulDiv),
    .branch_taken  (branch_taken),
    .md_done       (md_done),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events),
`endif
    .PC_Write      (PC_Write),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .ID_EX_Write   (ID_EX_Write),
    .ID_EX_Flush   (ID_EX_Flush),
    .EX_MEM_Flush  (EX_MEM_Flush),
    .md_start      (md_start),
    .md_abort      (md_abort)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic r, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic md, input logic br, input logic dn);
    rst = r; IF_ID_rs1 = rs1; IF_ID_use_rs1 = u1; IF_ID_rs2 = rs2; IF_ID_use_rs2 = u2;
    ID_EX_rd = rd; ID_EX_MemRead = mr; ID_EX_MulDiv = md; branch_taken = br; md_done = dn;
  endtask

  // Evaluate one cycle against the model, then clock it.
  task automatic step(input string tag);
    logic [7:0] exp, obs;
    bit         lu, nb, stalled, flushed;
    int         nn;
    #1;
    lu = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
         ((IF_ID_use_rs1 && ID_EX_rd == IF_ID_rs1) || (IF_ID_use_rs2 && ID_EX_rd == IF_ID_rs2));
    nb = m_busy; nn = m_busy_n; flushed = 1'b0;
    if (rst) begin
      exp = 8'b00101100; nb = 1'b0;
    end else if (!m_busy) begin
      if (branch_taken) begin exp = 8'b11111000; flushed = 1'b1; end
      else if (ID_EX_MulDiv) begin exp = 8'b00000110; nb = 1'b1; nn = 1; end
      else if (lu) exp = 8'b00011000;
      else exp = 8'b11010000;
    end else begin
      if (md_done) begin exp = 8'b11010000; nb = 1'b0; end
      else if (m_busy_n == TO) begin exp = 8'b00000101; nb = 1'b0; end
      else begin exp = 8'b00000100; nn = m_busy_n + 1; end
    end
    obs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
           ID_EX_Flush, EX_MEM_Flush, md_start, md_abort};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    assert ({stall_cycles, flush_events} === {m_stall, m_flush}) else begin
      n_err++;
      $error("FAIL %s perf observed=%0d/%0d expected=%0d/%0d", tag,
             stall_cycles, flush_events, m_stall, m_flush);
    end
`endif
    stalled = !rst && (exp[7] == 1'b0);
    @(posedge clk);
    m_busy = nb; m_busy_n = nn;
    if (rst) begin
      m_stall = 32'd0; m_flush = 32'd0;
    end else begin
      if (stalled) m_stall = m_stall + 32'd1;
      if (flushed) m_flush = m_flush + 32'd1;
    end
    #1;
  endtask

  initial begin
    // Reset
    set_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset0");
    step("reset1");

    // lw x5 ; add x6,x5,x1 -> one bubble, then released
    set_in(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_stall");
    set_in(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_release");
    // lw x0, ID reads x0 -> no stall
    set_in(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_x0");
    // rs2 matches but not read -> no stall
    set_in(1'b0, 5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2_unused");
    // rs2 matches and read -> stall
    set_in(1'b0, 5'd3, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2_used");
    // load-use plus branch -> flush wins
    set_in(1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    step("lu_branch");

    // MUL with md_done 5 cycles after start
    set_in(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step("md_start");
    for (int i = 0; i < 4; i++) step("md_busy");
    md_done = 1'b1;
    step("md_done");
    set_in(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step("md_after");
    md_done = 1'b1;
    step("md_done_in_run");

    // Watchdog: no md_done
    set_in(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step("wd_start");
    for (int i = 0; i < TO; i++) step("wd_busy");
    ID_EX_MulDiv = 1'b0;
    step("wd_after");

    // Reset during MD_BUSY
    ID_EX_MulDiv = 1'b1;
    step("rb_start");
    step("rb_busy");
    rst = 1'b1;
    step("rb_reset");
    rst = 1'b0; ID_EX_MulDiv = 1'b0;
    step("rb_run");

`ifdef HAZARD_PERF_CNT_EN
    // 3 load-use stalls plus 2 branches from a fresh reset
    rst = 1'b1;
    step("pc_reset");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      step("pc_stall");
      set_in(1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      step("pc_gap");
    end
    for (int i = 0; i < 2; i++) begin
      branch_taken = 1'b1;
      step("pc_branch");
      branch_taken = 1'b0;
      step("pc_gap");
    end
    #1;
    n_vec++;
    assert ({stall_cycles, flush_events} === {32'd3, 32'd2}) else begin
      n_err++;
      $error("FAIL perf_totals observed=%0d/%0d expected=3/2", stall_cycles, flush_events);
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      set_in(1'($urandom_range(0, 60) == 0),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 4),
             1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 2),
             1'($urandom_range(0, 9) == 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
